// File: rtl/additive_voice_engine.sv
// additive_voice_engine: sums scaled sine harmonics per sample period and ships the result to an SPI DAC
module additive_voice_engine #(
  parameter int          NUM_HARMONICS   = 20,
  parameter int          NUM_CHANNELS    = 1,
  parameter int          DIV_BIT         = 7,
  parameter int          SAMPLE_INTERVAL = 1500,
  parameter logic [31:0] OUTPUT_OFFSET   = 32'h31000,
  parameter int          OUTPUT_SHIFT    = 3
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [7:0]  i_harmonic_count,
  input  logic [5:0]  i_scale,
  input  logic        i_sample_ready,
  input  logic [15:0] i_sample_value,
  input  logic        i_dac_busy,
  output logic [7:0]  o_harmonic,
  output logic        o_next_sample,
  output logic [23:0] o_dac_data,
  output logic        o_dac_send,
  output logic        o_overrun
);
  localparam int TW = $clog2(SAMPLE_INTERVAL);
  localparam int PW = 17 + DIV_BIT;
  typedef enum logic [2:0] {INIT, REQUEST, WAIT_SAMPLE, ACCUMULATE, FINALISE, WAIT_SLOT, SEND_A, SEND_B} state_t;
  function automatic logic [15:0] f_scale(input logic signed [31:0] acc);
    logic signed [31:0] v;
    v = (acc + $signed(OUTPUT_OFFSET)) >>> OUTPUT_SHIFT;
    return v < 0 ? 16'd0 : v > 32'sd65535 ? 16'hffff : v[15:0];
  endfunction
  localparam logic [15:0] HOLD_RESET = f_scale(32'sd0);
  state_t                    r_state, w_next_state;
  logic [TW-1:0]             r_timer;
  logic [7:0]                r_harm, r_count;
  logic [5:0]                r_scale;
  logic [DIV_BIT-1:0]        r_mult, w_mult_next;
  logic signed [15:0]        r_sample;
  logic signed [31:0]        r_acc_a, r_acc_b, w_term;
  logic signed [PW-1:0]      w_prod;
  logic [15:0]               r_out_a, r_out_b;
  logic                      r_armed, r_next_sample, r_dac_send, r_overrun;
  logic [23:0]               r_dac_data;
  logic [7:0]                w_n;
  logic                      w_slot, w_overrun, w_last, w_to_b;
  logic                      w_init, w_consume, w_acc, w_fin, w_send_a, w_send_b;
  assign w_slot      = r_timer == TW'(SAMPLE_INTERVAL - 1);
  assign w_overrun   = w_slot && (r_state inside {INIT, REQUEST, WAIT_SAMPLE, ACCUMULATE, FINALISE});
  assign w_n         = i_harmonic_count > 8'(NUM_HARMONICS) ? 8'(NUM_HARMONICS) : i_harmonic_count;
  assign w_last      = r_harm + 8'd1 == r_count;
  assign w_to_b      = NUM_CHANNELS == 2 && r_harm[0];
  assign w_prod      = PW'(r_sample) * PW'($signed({1'b0, r_mult}));
  assign w_term      = 32'(w_prod >>> DIV_BIT);
  assign w_mult_next = 32'(r_mult) > 32'(r_scale) ? r_mult - DIV_BIT'(r_scale) : '0;
  assign o_harmonic    = r_harm;
  assign o_next_sample = r_next_sample;
  assign o_dac_data    = r_dac_data;
  assign o_dac_send    = r_dac_send;
  assign o_overrun     = r_overrun;
  // state register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= INIT;
    else r_state <= w_next_state;
  end
  // next state; a slot during calculation preempts it and resends the held words
  always_comb begin
    w_next_state = r_state;
    if (w_overrun) w_next_state = SEND_A;
    else case (r_state)
      INIT:        w_next_state = w_n == 8'd0 ? FINALISE : REQUEST;
      REQUEST:     w_next_state = WAIT_SAMPLE;
      WAIT_SAMPLE: w_next_state = i_sample_ready ? ACCUMULATE : WAIT_SAMPLE;
      ACCUMULATE:  w_next_state = w_last ? FINALISE : REQUEST;
      FINALISE:    w_next_state = WAIT_SLOT;
      WAIT_SLOT:   w_next_state = w_slot ? SEND_A : WAIT_SLOT;
      SEND_A:      w_next_state = i_dac_busy ? SEND_A : NUM_CHANNELS == 2 ? SEND_B : INIT;
      SEND_B:      w_next_state = r_armed && !i_dac_busy ? INIT : SEND_B;
      default:     w_next_state = INIT;
    endcase
  end
  // per-state actions; calculation steps are suppressed when the slot preempts them
  always_comb begin
    w_init    = r_state == INIT && !w_overrun;
    w_consume = r_state == WAIT_SAMPLE && i_sample_ready && !w_overrun;
    w_acc     = r_state == ACCUMULATE && !w_overrun;
    w_fin     = r_state == FINALISE && !w_overrun;
    w_send_a  = r_state == SEND_A && !i_dac_busy;
    w_send_b  = r_state == SEND_B && r_armed && !i_dac_busy;
  end
  // timer, accumulators, held outputs and DAC handshake; SEND_B skips its first cycle so busy from A is seen
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_timer       <= '0;
      r_harm        <= '0;
      r_count       <= '0;
      r_scale       <= '0;
      r_mult        <= '1;
      r_sample      <= '0;
      r_acc_a       <= '0;
      r_acc_b       <= '0;
      r_out_a       <= HOLD_RESET;
      r_out_b       <= HOLD_RESET;
      r_armed       <= 1'b0;
      r_next_sample <= 1'b0;
      r_dac_send    <= 1'b0;
      r_dac_data    <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_timer       <= w_slot ? '0 : r_timer + TW'(1);
      r_next_sample <= w_consume;
      r_dac_send    <= w_send_a || w_send_b;
      r_armed       <= r_state == SEND_B;
      if (w_overrun) r_overrun <= 1'b1;
      if (w_init) begin
        r_acc_a <= '0;
        r_acc_b <= '0;
        r_harm  <= '0;
        r_mult  <= '1;
        r_count <= w_n;
        r_scale <= i_scale;
      end
      if (w_consume) r_sample <= i_sample_value;
      if (w_acc) begin
        if (w_to_b) r_acc_b <= r_acc_b + w_term;
        else r_acc_a <= r_acc_a + w_term;
        r_mult <= w_mult_next;
        r_harm <= r_harm + 8'd1;
      end
      if (w_fin) begin
        r_out_a <= f_scale(r_acc_a);
        r_out_b <= f_scale(r_acc_b);
      end
      if (w_send_a) r_dac_data <= {8'b00110001, r_out_a};
      if (w_send_b) r_dac_data <= {8'b00110010, r_out_b};
    end
  end
endmodule

// File: tb/tb_additive_voice_engine.sv
// tb_additive_voice_engine: randomized scoreboard bench for the two-channel additive voice engine
module tb_additive_voice_engine;
  localparam int SI = 300;
  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_harmonic_count = 8'd0;
  logic [5:0]  i_scale = 6'd0;
  logic        i_sample_ready;
  logic [15:0] i_sample_value;
  logic        i_dac_busy;
  logic [7:0]  o_harmonic;
  logic        o_next_sample;
  logic [23:0] o_dac_data;
  logic        o_dac_send;
  logic        o_overrun;
  int          tests = 0;
  int          fails = 0;
  int          tbl[20];
  int          ready_delay = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  additive_voice_engine #(.NUM_CHANNELS(2), .SAMPLE_INTERVAL(SI)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_harmonic_count(i_harmonic_count), .i_scale(i_scale),
    .i_sample_ready(i_sample_ready), .i_sample_value(i_sample_value), .i_dac_busy(i_dac_busy),
    .o_harmonic(o_harmonic), .o_next_sample(o_next_sample), .o_dac_data(o_dac_data),
    .o_dac_send(o_dac_send), .o_overrun(o_overrun));

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: harmonic h gets amplitude max(0, 127 - h*scale)/128; even h to channel A, odd to B
  function automatic void model(input int cnt, input int scl, output logic [23:0] a, output logic [23:0] b);
    longint acc[2];
    longint v;
    int     n;
    int     m;
    acc[0] = 0;
    acc[1] = 0;
    n = cnt > 20 ? 20 : cnt;
    for (int h = 0; h < n; h++) begin
      m = 127 - h * scl;
      if (m < 0) m = 0;
      acc[h % 2] += (longint'(tbl[h]) * m) >>> 7;
    end
    v = (acc[0] + 200704) >>> 3;
    a = {8'h31, v < 0 ? 16'd0 : v > 65535 ? 16'hffff : 16'(v)};
    v = (acc[1] + 200704) >>> 3;
    b = {8'h32, v < 0 ? 16'd0 : v > 65535 ? 16'hffff : 16'(v)};
  endfunction

  // Sample source: presents tbl[o_harmonic], ready after ready_delay cycles since the last consume
  initial begin : source
    int wc;
    wc = 0;
    i_sample_ready = 1'b0;
    i_sample_value = 16'd0;
    forever begin
      @(posedge clk); #1;
      if (o_next_sample || i_reset) wc = 0;
      else wc++;
      i_sample_ready = wc >= ready_delay;
      i_sample_value = o_harmonic < 8'd20 ? 16'(tbl[o_harmonic]) : 16'd0;
    end
  end

  // Monitor and DAC model: pops expected words on each send, checks slot timing and busy gaps
  initial begin : monitor
    int          busy_cnt;
    int          since_rst;
    int          since_a;
    logic        first_a;
    logic        changed;
    logic [23:0] last;
    busy_cnt  = 0;
    since_rst = 0;
    since_a   = 0;
    first_a   = 1'b1;
    changed   = 1'b0;
    last      = 24'h0;
    i_dac_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      since_a++;
      if (i_reset) begin
        check("send_in_reset", o_dac_send, 0);
        since_rst = 0;
        first_a   = 1'b1;
        changed   = 1'b0;
        last      = 24'h0;
      end else since_rst++;
      if (!i_reset && o_dac_send) begin
        check("dac_hold", changed, 0);
        check("busy_gap", i_dac_busy, 0);
        if (o_dac_data[23:16] == 8'h31) begin
          if (first_a) check("first_slot", since_rst, SI + 1);
          else check("slot_interval", since_a, SI);
          first_a = 1'b0;
          since_a = 0;
        end
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_send: got %0h, expected no send", o_dac_data);
        end else check("dac_word", o_dac_data, exp_q.pop_front());
        busy_cnt = $urandom_range(0, 10);
        last     = o_dac_data;
        changed  = 1'b0;
      end else begin
        if (o_dac_data != last) changed = 1'b1;
        if (busy_cnt > 0) busy_cnt--;
      end
      i_dac_busy = busy_cnt > 0;
    end
  end

  task automatic drain(input int periods);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < periods * SI + 400) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Configure a period, reset into it, then expect `periods` A/B pairs (held offset words on overrun)
  task automatic run_test(input int cnt, input int scl, input int dly, input int periods,
                          input bit rnd, input int fill, input bit overrun);
    logic [23:0] a;
    logic [23:0] b;
    @(negedge clk);
    for (int h = 0; h < 20; h++) tbl[h] = rnd ? int'($urandom_range(0, 65535)) - 32768 : fill;
    i_harmonic_count = 8'(cnt);
    i_scale = 6'(scl);
    ready_delay = dly;
    i_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    if (overrun) model(0, 0, a, b);
    else model(cnt, scl, a, b);
    for (int p = 0; p < periods; p++) begin
      exp_q.push_back(a);
      exp_q.push_back(b);
    end
    drain(periods);
    check("overrun_flag", o_overrun, overrun);
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    run_test(5, 0, 0, 2, 0, 0, 0);
    run_test(1, 0, 0, 1, 0, 16384, 0);
    run_test(20, 0, 1, 1, 0, -32768, 0);
    run_test(2, 0, 0, 1, 0, 16384, 0);
    run_test(0, 5, 0, 1, 1, 0, 0);
    run_test(255, 2, 2, 1, 1, 0, 0);
    for (int t = 0; t < 8; t++)
      run_test($urandom_range(0, 3) == 0 ? int'($urandom_range(21, 255)) : int'($urandom_range(0, 20)),
               $urandom_range(0, 63), $urandom_range(0, 3), 1, 1, 0, 0);
    run_test(20, 0, 30, 2, 1, 0, 1);
    run_test(20, 3, 5, 0, 1, 0, 0);
    repeat (40) @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk); #1;
    check("rst_harmonic", o_harmonic, 0);
    check("rst_next_sample", o_next_sample, 0);
    check("rst_dac_send", o_dac_send, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_dac_data", o_dac_data, 0);
    run_test(20, 3, 0, 1, 1, 0, 0);
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
